// File: rtl/mp_window_avg.sv
// Windowed averager for the interleaved CORDIC magnitude/phase stream.
// Averages 2^k pairs; phase is averaged as offsets from the window's first phase.
module mp_window_avg #(
  parameter int dw        = 18,
  parameter int max_log2n = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 phase,
  input  logic signed [dw-1:0] in_mp,
  input  logic                 run,
  input  logic [3:0]           log2n,
  output logic signed [dw-1:0] mag_out,
  output logic signed [dw-1:0] ph_out,
  output logic                 out_valid,
  output logic                 sync_err
);

  localparam int aw = dw + max_log2n;
  localparam int cw = max_log2n;

  logic signed [dw-1:0] m_hold;
  logic signed [dw-1:0] ref_p;
  logic                 m_ok;
  logic [cw-1:0]        cnt;
  logic [3:0]           k_w;
  logic signed [aw-1:0] acc_m;
  logic signed [aw-1:0] acc_d;
  logic                 done;

  logic [3:0]           k_clamp;
  logic [3:0]           k_eff;
  logic [cw:0]          n_eff;
  logic [cw-1:0]        last_cnt;
  logic                 first;
  logic signed [dw-1:0] d;
  logic signed [aw-1:0] m_ext;
  logic signed [aw-1:0] d_ext;
  logic [dw-1:0]        mag_avg;
  logic [dw-1:0]        ph_off;
  logic [dw-1:0]        ph_sum;

  always_comb begin
    k_clamp  = (log2n > 4'(max_log2n)) ? 4'(max_log2n) : log2n;
    first    = (cnt == '0);
    // The window length is fixed by the exponent seen at its first pair.
    k_eff    = first ? k_clamp : k_w;
    n_eff    = (cw+1)'(1) << k_eff;
    last_cnt = cw'(n_eff - (cw+1)'(1));
    // Truncating the difference to dw bits gives the shortest-arc offset.
    d        = in_mp - ref_p;
    m_ext    = {{max_log2n{m_hold[dw-1]}}, m_hold};
    d_ext    = {{max_log2n{d[dw-1]}}, d};
    mag_avg  = dw'(acc_m >>> k_w);
    ph_off   = dw'(acc_d >>> k_w);
    ph_sum   = ref_p + ph_off;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hold    <= '0;
      ref_p     <= '0;
      m_ok      <= 1'b0;
      cnt       <= '0;
      k_w       <= '0;
      acc_m     <= '0;
      acc_d     <= '0;
      done      <= 1'b0;
      mag_out   <= '0;
      ph_out    <= '0;
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      out_valid <= done;
      if (done) begin
        mag_out <= mag_avg;
        ph_out  <= ph_sum;
      end
      done <= 1'b0;
      if (!run) begin
        cnt      <= '0;
        m_ok     <= 1'b0;
        sync_err <= 1'b0;
      end else if (!phase) begin
        m_hold <= in_mp;
        m_ok   <= 1'b1;
      end else if (m_ok) begin
        m_ok <= 1'b0;
        if (first) begin
          k_w   <= k_clamp;
          ref_p <= in_mp;
          acc_m <= m_ext;
          acc_d <= '0;
        end else begin
          acc_m <= acc_m + m_ext;
          acc_d <= acc_d + d_ext;
        end
        if (cnt == last_cnt) begin
          cnt  <= '0;
          done <= 1'b1;
        end else begin
          cnt <= cnt + cw'(1);
        end
      end else begin
        sync_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mp_window_avg.sv
// Randomised and directed bench for mp_window_avg with a window-level reference
// model feeding a scoreboard that a separate monitor drains on each strobe.
module tb_mp_window_avg;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               phase = 1'b0;
  logic signed [17:0] in_mp = '0;
  logic               run = 1'b0;
  logic [3:0]         log2n = '0;
  logic signed [17:0] mag_out;
  logic signed [17:0] ph_out;
  logic               out_valid;
  logic               sync_err;

  mp_window_avg #(.dw(18), .max_log2n(8)) dut (
    .clk(clk), .rst_n(rst_n), .phase(phase), .in_mp(in_mp), .run(run),
    .log2n(log2n), .mag_out(mag_out), .ph_out(ph_out),
    .out_valid(out_valid), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    longint mag;
    longint ph;
    int     at;
  } exp_t;

  exp_t   sbq[$];
  int     compared = 0;
  int     mismatched = 0;

  longint win_m[$];
  longint win_p[$];
  int     win_k = 0;
  bit     mdl_ok = 0;
  longint mdl_hold = 0;
  bit     mdl_err = 0;

  function automatic longint wrap18(longint x);
    longint y = x & 64'h3FFFF;
    if (y >= 131072) y -= 262144;
    return y;
  endfunction

  function automatic longint floor_div(longint s, int k);
    longint n = longint'(1) << k;
    longint q = s / n;
    if ((s % n) != 0 && s < 0) q--;
    return q;
  endfunction

  task automatic chk(string name, longint act, longint exp_v);
    compared++;
    if (act !== exp_v) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp_v, edge_cnt);
    end
  endtask

  task automatic model_reset();
    win_m.delete();
    win_p.delete();
    mdl_ok  = 0;
    mdl_err = 0;
    sbq.delete();
  endtask

  // Window-level reference: collect pairs, then average from the arithmetic definition.
  task automatic model_edge(bit r, bit ph, longint data, int lg);
    exp_t   e;
    longint sm, sd;
    if (!r) begin
      mdl_ok  = 0;
      mdl_err = 0;
      win_m.delete();
      win_p.delete();
    end else if (!ph) begin
      mdl_hold = data;
      mdl_ok   = 1;
    end else if (mdl_ok) begin
      mdl_ok = 0;
      if (win_m.size() == 0) win_k = (lg > 8) ? 8 : lg;
      win_m.push_back(mdl_hold);
      win_p.push_back(data);
      if (win_m.size() == (1 << win_k)) begin
        sm = 0;
        sd = 0;
        foreach (win_m[i]) begin
          sm += win_m[i];
          sd += wrap18(win_p[i] - win_p[0]);
        end
        e.mag = wrap18(floor_div(sm, win_k));
        e.ph  = wrap18(win_p[0] + floor_div(sd, win_k));
        e.at  = edge_cnt + 1;
        sbq.push_back(e);
        win_m.delete();
        win_p.delete();
      end
    end else begin
      mdl_err = 1;
    end
  endtask

  task automatic step(bit r, bit ph, longint data);
    run   = r;
    phase = ph;
    in_mp = 18'(data);
    @(posedge clk);
    #1;
    model_edge(r, ph, data, int'(log2n));
    chk("sync_err", longint'(sync_err), longint'(mdl_err));
  endtask

  task automatic pair(longint m, longint p);
    step(1, 0, m);
    step(1, 1, p);
  endtask

  task automatic flush(int n);
    repeat (n) step(1, 0, 0);
  endtask

  function automatic longint rnd18();
    logic signed [17:0] t;
    t = 18'($urandom);
    return longint'(t);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid) begin
      if (sbq.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_strobe: got out_valid at edge %0d, expected none", edge_cnt);
      end else begin
        e = sbq.pop_front();
        chk("mag_out", longint'(mag_out), e.mag);
        chk("ph_out", longint'(ph_out), e.ph);
        chk("latency_edge", longint'(edge_cnt), longint'(e.at));
      end
    end
  end

  initial begin
    int r;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_mag", longint'(mag_out), 0);
    chk("reset_ph", longint'(ph_out), 0);
    chk("reset_valid", longint'(out_valid), 0);
    chk("reset_sync", longint'(sync_err), 0);
    #2 rst_n = 1'b1;

    // Plain magnitude average.
    log2n = 2;
    pair(100, 0); pair(200, 0); pair(300, 0); pair(400, 0);
    flush(3);
    chk("mag_avg_hold", longint'(mag_out), 250);

    // Wrap-safe phase average across the +/-pi seam.
    log2n = 1;
    pair(1000, 131000); pair(1000, -131000);
    flush(3);
    chk("wrap_not_naive", longint'(ph_out != 0), 1);
    chk("wrap_ph_hold", longint'(ph_out), -131072);

    // Orphan phase words raise sync_err; run=0 clears it.
    step(0, 0, 0);
    step(1, 1, 5);
    step(1, 1, 6);
    log2n = 0;
    pair(7, 8);
    flush(2);
    step(0, 0, 0);

    // Back-to-back single-pair windows.
    log2n = 0;
    for (int i = 1; i <= 5; i++) pair(10 * i, -i);
    flush(3);

    // Aborted window followed by a full one.
    log2n = 3;
    for (int i = 1; i <= 5; i++) pair(3 * i, i);
    step(0, 0, 0);
    step(0, 0, 0);
    for (int i = 0; i < 8; i++) pair(64, -2000);
    flush(3);

    // Async reset mid-window, then a window whose log2n changes after pair 2.
    log2n = 3;
    pair(10, 100); pair(20, 200);
    log2n = 1;
    pair(30, 300);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_mag", longint'(mag_out), 0);
    chk("arst_ph", longint'(ph_out), 0);
    chk("arst_valid", longint'(out_valid), 0);
    chk("arst_sync", longint'(sync_err), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    log2n = 3;
    pair(1000, 500); pair(2000, 600);
    log2n = 1;
    for (int i = 3; i <= 8; i++) pair(1000 * i, 100 * i + 300);
    flush(3);

    // Exponent above the maximum clamps to 256 pairs.
    log2n = 12;
    for (int i = 0; i < 256; i++) pair(rnd18(), rnd18());
    flush(3);

    // Randomised traffic with glitches, aborts and exponent changes.
    log2n = 2;
    for (int n = 0; n < 2000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 4)       step(0, 0, rnd18());
      else if (r < 10) step(1, 1, rnd18());
      else if (r < 16) step(1, 0, rnd18());
      else if (r < 22) log2n = 4'($urandom_range(0, 4));
      else             pair(rnd18(), rnd18());
    end
    flush(5);
    chk("scoreboard_drained", longint'(sbq.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
